// File: rtl/bus_irq_pkg.sv
// bus_irq_pkg: shared FSM state type, address defaults and sizing constants for
// bus_interrupt_arbiter. The round-robin helper below is only referenced when the
// design is built with IRQ_ROUND_ROBIN_EN defined.
package bus_irq_pkg;

    localparam int unsigned IRQ_ID_W            = 3;
    localparam int unsigned IRQ_MAX_SRC         = 8;
    localparam logic [7:0]  MASK_ADDR_DEFAULT   = 8'hF0;
    localparam logic [7:0]  STATUS_ADDR_DEFAULT = 8'hF1;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StAck,
        StHoldoff
    } irq_state_e;

    // One past idx, wrapping back to zero at num_src.
    function automatic logic [IRQ_ID_W-1:0] next_index(input logic [IRQ_ID_W-1:0] idx,
                                                       input int unsigned         num_src);
        int unsigned nxt;
        nxt = 32'(idx) + 32'd1;
        if (nxt >= num_src) begin
            nxt = 0;
        end
        return nxt[IRQ_ID_W-1:0];
    endfunction

endpackage

// File: rtl/irq_priority_select.sv
// irq_priority_select: picks one pending source from the pending vector.
// Build option IRQ_ROUND_ROBIN_EN: when defined, the search starts at i_ptr and wraps
// at NUM_SRC; when undefined, the lowest pending index wins and i_ptr is ignored.
module irq_priority_select
    import bus_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]  i_pending,
    input  logic [IRQ_ID_W-1:0] i_ptr,
    output logic [IRQ_ID_W-1:0] o_winner,
    output logic                o_valid
);

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IRQ_ID_W-1:0] w_idx;
    logic [NUM_SRC-1:0]  w_bit;

    // Walk indices ptr, ptr+1, ... (mod NUM_SRC) and keep the first pending one.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = '0;
        w_bit    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_idx = IRQ_ID_W'((32'(i_ptr) + k) % NUM_SRC);
            w_bit = NUM_SRC'(1) << w_idx;
            if (!o_valid && ((i_pending & w_bit) != '0)) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end
        end
    end
`else
    logic [NUM_SRC-1:0] w_shift;
    logic               w_unused_ptr;

    // Fixed priority: lowest pending index wins.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_shift  = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_shift = i_pending >> k;
            if (!o_valid && w_shift[0]) begin
                o_valid  = 1'b1;
                o_winner = IRQ_ID_W'(k);
            end
        end
    end

    assign w_unused_ptr = ^i_ptr;
`endif

endmodule

// File: rtl/bus_interrupt_arbiter.sv
// bus_interrupt_arbiter: shares one CPU interrupt line among NUM_SRC level-request
// peripherals, returns the CPU acknowledge as a one-cycle pulse to the granted source,
// and exposes a mask register and a pending-status register on the bus.
// Build option IRQ_ROUND_ROBIN_EN: when defined, arbitration is round-robin with a
// pointer that advances past each acknowledged source; otherwise fixed priority.
module bus_interrupt_arbiter
    import bus_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 4,
    parameter logic [7:0]  MASK_ADDR   = MASK_ADDR_DEFAULT,
    parameter logic [7:0]  STATUS_ADDR = STATUS_ADDR_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NUM_SRC-1:0]  i_irq_raise,
    output logic [NUM_SRC-1:0]  o_irq_ack,
    output logic                o_cpu_int_raise,
    output logic [IRQ_ID_W-1:0] o_cpu_int_id,
    input  logic                i_cpu_int_ack,
    inout  wire  [7:0]          io_bus_data,
    input  logic [7:0]          i_bus_addr,
    input  logic                i_bus_we
);

    irq_state_e          r_state;
    irq_state_e          w_state_d;
    logic [IRQ_ID_W-1:0] r_id;
    logic [NUM_SRC-1:0]  r_mask;
    logic [7:0]          r_rd_data;
    logic                r_rd_en;

    logic [NUM_SRC-1:0]  w_pending;
    logic [IRQ_ID_W-1:0] w_winner;
    logic [IRQ_ID_W-1:0] w_ptr;
    logic                w_valid;
    logic                w_grant_start;
    logic                w_ack_start;
    logic                w_mask_wr;
    logic                w_rd_hit;
    logic [7:0]          w_mask_ext;
    logic [7:0]          w_pending_ext;
    logic [7:0]          w_rd_data;
    logic                w_unused_bus;

    // Uses the mask as it stood before any write on this edge.
    assign w_pending = i_irq_raise & r_mask;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IRQ_ID_W-1:0] r_ptr;

    // Round-robin pointer moves one past the winner as its acknowledge begins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (w_ack_start) begin
            r_ptr <= next_index(r_id, NUM_SRC);
        end
    end

    assign w_ptr = r_ptr;
`else
    logic w_unused_ack_start;

    assign w_ptr              = '0;
    assign w_unused_ack_start = w_ack_start;
`endif

    irq_priority_select #(
        .NUM_SRC (NUM_SRC)
    ) u_select (
        .i_pending (w_pending),
        .i_ptr     (w_ptr),
        .o_winner  (w_winner),
        .o_valid   (w_valid)
    );

    // FSM state register; the winner ID is frozen for the whole grant.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_id    <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_grant_start) begin
                r_id <= w_winner;
            end
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_d       = r_state;
        w_grant_start   = 1'b0;
        w_ack_start     = 1'b0;
        o_cpu_int_raise = 1'b0;
        o_irq_ack       = '0;
        unique case (r_state)
            StIdle: begin
                if (w_valid) begin
                    w_grant_start = 1'b1;
                    w_state_d     = StGrant;
                end
            end
            StGrant: begin
                // The grant stays up even if the source drops or gets masked.
                o_cpu_int_raise = 1'b1;
                if (i_cpu_int_ack) begin
                    w_ack_start = 1'b1;
                    w_state_d   = StAck;
                end
            end
            StAck: begin
                o_irq_ack = NUM_SRC'(1) << r_id;
                w_state_d = StHoldoff;
            end
            StHoldoff: begin
                // Gives the source a cycle to drop its registered raise.
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign o_cpu_int_id = r_id;

    // Mask register; writes to the status address are simply not decoded.
    assign w_mask_wr = i_bus_we && (i_bus_addr == MASK_ADDR);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mask <= '1;
        end else if (w_mask_wr) begin
            r_mask <= io_bus_data[NUM_SRC-1:0];
        end
    end

    // Zero-fill the register views up to the bus width.
    always_comb begin
        w_mask_ext                   = '0;
        w_mask_ext[NUM_SRC-1:0]      = r_mask;
        w_pending_ext                = '0;
        w_pending_ext[NUM_SRC-1:0]   = w_pending;
    end

    assign w_rd_hit  = !i_bus_we && ((i_bus_addr == MASK_ADDR) || (i_bus_addr == STATUS_ADDR));
    assign w_rd_data = (i_bus_addr == MASK_ADDR) ? w_mask_ext : w_pending_ext;

    // Read data and drive enable are captured together; the bus is driven next cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_en   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_en <= w_rd_hit;
            if (w_rd_hit) begin
                r_rd_data <= w_rd_data;
            end
        end
    end

    assign io_bus_data  = r_rd_en ? r_rd_data : 8'hzz;
    assign w_unused_bus = ^io_bus_data;

endmodule

// File: doc/bus_interrupt_arbiter.md
# bus_interrupt_arbiter

Shares the processor's single interrupt input between up to eight bus peripherals (mouse, timer, IR, etc.), each of which holds a level interrupt request until acknowledged. Picks one pending, unmasked source, presents it to the CPU with its source ID, and routes the CPU's acknowledge back as a one-cycle pulse to that source only. Sits between the peripherals' interrupt raise/ack pairs and the processor; also a bus slave exposing a mask register and a pending-status register.

## Interface
- NUM_SRC, 4: number of interrupt sources, legal range 2..8; source 0 is highest fixed priority.
- MASK_ADDR, 8'hF0: read/write interrupt-enable mask register.
- STATUS_ADDR, 8'hF1: read-only pending register.
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- IRQ_RAISE  in  NUM_SRC  per-source level request; held high by source until acked.
- IRQ_ACK  out  NUM_SRC  per-source one-cycle acknowledge pulse, one-hot or zero.
- CPU_INT_RAISE  out  1  interrupt request to processor.
- CPU_INT_ID  out  3  index of granted source; valid while CPU_INT_RAISE high.
- CPU_INT_ACK  in  1  processor acknowledge.
- BUS_DATA  inout  8  shared data bus; driven only during reads of this block.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  processor write enable.

## Operation
- pending = IRQ_RAISE & mask[NUM_SRC-1:0]; STATUS reads {zero-fill, pending}.
- FSM states: IDLE, GRANT, ACK, HOLDOFF.
- IDLE: if pending != 0, latch winner into CPU_INT_ID, go GRANT; CPU_INT_ACK ignored.
- GRANT: CPU_INT_RAISE=1; winner is not revoked if its request drops or it is masked; on CPU_INT_ACK go ACK.
- ACK: IRQ_ACK[CPU_INT_ID]=1 for exactly this cycle, CPU_INT_RAISE=0; go HOLDOFF.
- HOLDOFF: one cycle, no grant, lets source deassert its registered raise; go IDLE.
- Mask write: BUS_WE=1 and BUS_ADDR==MASK_ADDR -> mask <= BUS_DATA at that edge; upper unused bits read as 0.
- Read: BUS_WE=0 and BUS_ADDR in {MASK_ADDR, STATUS_ADDR} -> output data and drive enable registered on the same edge; BUS_DATA driven the following cycle, high-Z otherwise.
- Writes to STATUS_ADDR ignored.

## Timing
- Reset values: state IDLE, CPU_INT_RAISE 0, CPU_INT_ID 0, IRQ_ACK 0, mask all ones, BUS_DATA high-Z, round-robin pointer 0.
- Request to CPU_INT_RAISE: 1 cycle (raise seen at edge t -> output high after t+1... i.e. visible in cycle t+1).
- CPU_INT_ACK sampled at edge t in GRANT -> IRQ_ACK pulse during cycle t+1, CPU_INT_RAISE low same cycle.
- Minimum spacing between grant starts: 4 cycles (IDLE, GRANT, ACK, HOLDOFF).
- Simultaneous mask write and arbitration: arbitration uses the pre-write mask.
- Source still raised after HOLDOFF is re-arbitrated as a new request.
- RESET mid-GRANT or mid-ACK: all outputs to reset values next cycle; no ack pulse emitted.
- Bus read latency 1 cycle, matching existing bus peripherals.

## Configuration
- IRQ_ROUND_ROBIN_EN defined: winner is first pending index at or after pointer, wrapping at NUM_SRC; pointer <= winner+1 (mod NUM_SRC) on entering ACK.
- Undefined: fixed priority, lowest pending index wins; no pointer register.

## Structure
- Package bus_irq_pkg: FSM state enum, default MASK_ADDR/STATUS_ADDR constants, ID width constant (3), max source count (8).
- Sub-module irq_priority_select: takes pending vector and pointer, returns winner index and valid; owns the round-robin/fixed-priority choice under IRQ_ROUND_ROBIN_EN.

## Test plan
- Reset, IRQ_RAISE=4'b0010 -> CPU_INT_RAISE=1, CPU_INT_ID=1 one cycle later; CPU_INT_ACK pulse -> IRQ_ACK=4'b0010 for one cycle, CPU_INT_RAISE=0.
- IRQ_RAISE=4'b1010 held, fixed priority -> grants 1 then 3; round-robin build with sources re-raising -> alternates 1,3,1,3.
- Write 8'h0D to MASK_ADDR, IRQ_RAISE=4'b0010 -> no CPU_INT_RAISE; read STATUS_ADDR -> 8'h00; read MASK_ADDR -> 8'h0D.
- CPU_INT_ACK pulsed in IDLE -> no IRQ_ACK; source drops raise during GRANT -> grant held, ack still delivered to it.
- RESET asserted in GRANT -> CPU_INT_RAISE=0, IRQ_ACK=0, mask reads 8'h0F next cycle.
- BUS_ADDR=8'hF1 with BUS_WE=1 -> BUS_DATA stays high-Z, mask unchanged.
